// File: rtl/lzrw1_stream_decompressor.sv
// lzrw1_stream_decompressor: LZRW1 item decoder, ready/valid on both sides.
// Ports: clock, reset (sync, high); item side data_in, control_word_in,
//   data_in_last, data_in_valid/data_in_ready; byte side decompressed_byte,
//   out_last, out_valid/out_ready; byte_count per stream; error (sticky).
module lzrw1_stream_decompressor #(
  parameter int HISTORY_SIZE = 4096,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [15:0]            data_in,
  input  logic                   control_word_in,
  input  logic                   data_in_last,
  input  logic                   data_in_valid,
  output logic                   data_in_ready,
  output logic [7:0]             decompressed_byte,
  output logic                   out_valid,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic [COUNT_WIDTH-1:0] byte_count,
  output logic                   error
);

  localparam int AW = $clog2(HISTORY_SIZE);
  localparam int BW = AW + 1;
  localparam logic [12:0] HSIZE = 13'(HISTORY_SIZE);
  localparam logic [BW-1:0] BW_MAX = BW'(HISTORY_SIZE);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  typedef struct packed {
    logic [4:0]  remaining;
    logic [11:0] offset;
    logic        bad;
    logic        last;
  } item_t;

  state_t state_q;
  state_t state_d;

  item_t item_q;
  item_t item_d;

  logic [7:0] hist [HISTORY_SIZE];

  logic [AW-1:0]          wr_ptr_q;
  logic [AW-1:0]          wr_ptr_d;
  logic [BW-1:0]          written_q;
  logic [BW-1:0]          written_d;
  logic [COUNT_WIDTH-1:0] count_d;
  logic [7:0]             byte_d;
  logic                   last_d;

  logic out_hs;
  logic in_hs;
  logic final_hs;
  logic more_hs;
  logic drain_hs;

  logic [11:0]   in_off;
  logic [4:0]    in_len;
  logic          in_bad;
  logic [11:0]   cp_off;
  logic          cp_bad;
  logic [AW-1:0] rd_addr;
  logic [7:0]    cp_byte;

  // Handshake qualifiers
  assign out_hs   = (state_q == EMIT) && out_ready;
  assign final_hs = out_hs && (item_q.remaining == 5'd1);
  assign in_hs    = data_in_valid && data_in_ready;
  assign more_hs  = out_hs && !final_hs;
  assign drain_hs = final_hs && !in_hs;

  // Item field decode
  assign in_off = {data_in[15:12], data_in[7:0]};
  assign in_len = {1'b0, data_in[11:8]} + 5'd3;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (in_hs) begin
      state_d = EMIT;
    end else if (final_hs) begin
      state_d = IDLE;
    end
  end

  // FSM outputs; a new item is taken in the same cycle the
  // previous item's last byte leaves, so output stays gap-free
  always_comb begin
    out_valid     = (state_q == EMIT);
    data_in_ready = 1'b0;
    if (!reset) begin
      data_in_ready = (state_q == IDLE) || final_hs;
    end
  end

  // Pointer, fill level and stream counter after this cycle's
  // output handshake; legality of a new copy is judged on these
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    written_d = written_q;
    count_d   = byte_count;
    if (out_hs) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (out_last) begin
        written_d = '0;
        count_d   = '0;
      end else begin
        count_d = byte_count + COUNT_WIDTH'(1);
        if (written_q != BW_MAX) begin
          written_d = written_q + BW'(1);
        end
      end
    end
  end

  assign in_bad = (in_off == 12'd0)
    || ({1'b0, in_off} > 13'(written_d))
    || ({1'b0, in_off} >= HSIZE);

  // Copy byte source; the byte leaving this cycle is not in
  // the RAM yet, so an offset that lands on it is bypassed
  assign cp_off  = in_hs ? in_off : item_q.offset;
  assign cp_bad  = in_hs ? in_bad : item_q.bad;
  assign rd_addr = wr_ptr_d - cp_off[AW-1:0];

  always_comb begin
    cp_byte = hist[rd_addr];
    if (out_hs && (rd_addr == wr_ptr_q)) begin
      cp_byte = decompressed_byte;
    end
    if (cp_bad) begin
      cp_byte = 8'h00;
    end
  end

  // Next item context and output byte
  always_comb begin
    item_d = item_q;
    byte_d = decompressed_byte;
    last_d = out_last;
    unique case (1'b1)
      in_hs: begin
        item_d.offset = in_off;
        item_d.bad    = control_word_in && in_bad;
        item_d.last   = data_in_last;
        if (control_word_in) begin
          item_d.remaining = in_len;
          byte_d           = cp_byte;
          last_d           = 1'b0;
        end else begin
          item_d.remaining = 5'd1;
          byte_d           = data_in[7:0];
          last_d           = data_in_last;
        end
      end
      more_hs: begin
        item_d.remaining = item_q.remaining - 5'd1;
        byte_d           = cp_byte;
        last_d           = item_q.last
          && (item_q.remaining == 5'd2);
      end
      drain_hs: begin
        item_d.remaining = '0;
        last_d           = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      item_q            <= '0;
      decompressed_byte <= 8'h00;
      out_last          <= 1'b0;
      wr_ptr_q          <= '0;
      written_q         <= '0;
      byte_count        <= '0;
      error             <= 1'b0;
    end else begin
      item_q            <= item_d;
      decompressed_byte <= byte_d;
      out_last          <= last_d;
      wr_ptr_q          <= wr_ptr_d;
      written_q         <= written_d;
      byte_count        <= count_d;
      if (in_hs && control_word_in && in_bad) begin
        error <= 1'b1;
      end
    end
  end

  // History RAM: every byte that leaves is recorded
  always_ff @(posedge clock) begin
    if (out_hs && !reset) begin
      hist[wr_ptr_q] <= decompressed_byte;
    end
  end

endmodule

// File: doc/lzrw1_stream_decompressor.md
Name: lzrw1_stream_decompressor

Overview:
Next-generation LZRW1 item decompressor that replaces the busy-based decompressor_top interface with ready/valid handshakes on both sides. It adds output backpressure, per-stream framing (last), offset error detection and a per-stream byte count. The history depth is a parameter. It sits between the compressed-item unpacker (control-word bit plus 1- or 2-byte item) and the byte sink, and sustains 1 output byte per cycle.

Parameters:
HISTORY_SIZE, 4096, history RAM depth in bytes; power of 2, 16..4096.
COUNT_WIDTH, 16, width of the per-stream output byte counter.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
data_in  in  16  item; literal uses [7:0]; copy uses {off[11:8], len_code[3:0], off[7:0]}
control_word_in  in  1  1 = copy item, 0 = literal
data_in_last  in  1  item is the final item of a stream
data_in_valid  in  1  item present
data_in_ready  out  1  item accepted on clock edge when valid && ready
decompressed_byte  out  8  output byte
out_valid  out  1  byte present
out_last  out  1  final byte of a stream
out_ready  in  1  sink accepts byte on edge when out_valid && out_ready
byte_count  out  COUNT_WIDTH  bytes handshaken out in current stream, wraps
error  out  1  sticky, illegal copy offset seen

Behaviour:
- Reset values: data_in_ready=0 during reset and 1 on the first cycle after; out_valid=0, out_last=0, decompressed_byte=0, byte_count=0, error=0. History write pointer = 0 and bytes_written = 0.
- Reset asserted mid-item abandons the item. No further bytes are emitted for it.
- States:
  - IDLE: out_valid=0, data_in_ready=1.
  - EMIT: out_valid=1, bytes_remaining>=1.
- Literal accept: next cycle out_valid=1 with decompressed_byte=data_in[7:0], bytes_remaining=1.
- Copy accept:
  - length = len_code+3 (3..18).
  - offset = 12-bit field.
  - First byte is valid the next cycle. Then 1 byte per handshake cycle.
- Latency: 1 cycle from item accept to first out_valid.
- Byte source for a copy: history[(wr_ptr - offset) mod HISTORY_SIZE].
  - Overlapping copies (offset < length, including offset=1) must reproduce bytes written earlier in the same copy.
  - Write-to-read bypass is required so throughput stays 1 byte/cycle.
- Every byte handshaken out is written to history[wr_ptr]. wr_ptr then increments modulo HISTORY_SIZE.
  - bytes_written increments and saturates at HISTORY_SIZE.
  - byte_count increments and wraps at 2^COUNT_WIDTH.
- Illegal offset: offset==0, offset>bytes_written, or offset>=HISTORY_SIZE.
  - Sets error (cleared only by reset).
  - The item still emits `length` bytes, each 0x00, and these are written to history.
- Stall: while out_valid && !out_ready, decompressed_byte, out_last and all state hold. No byte is dropped or duplicated.
- data_in_ready = IDLE || (out_valid && out_ready && bytes_remaining==1). This is combinational from out_ready. Back-to-back items therefore give gap-free output.
- Simultaneous last-byte handshake and new-item accept: the new item's first byte appears next cycle.
- Stream framing:
  - data_in_last is latched with the item.
  - out_last=1 on that item's final byte only.
  - On its handshake, bytes_written and byte_count return to 0 (history contents are stale but unreachable) and wr_ptr holds.
  - error is unaffected.
- data_in_valid with data_in_ready=0: no effect. The source must hold the item.

Test Plan:
- Literals 0x61,0x62,0x63 then copy 16'h0303 (len 6, off 3), out_ready=1 -> "abcabcabc", one byte/cycle, byte_count=9, error=0.
- Literal 0x78 then copy 16'h0F01 (len 18, off 1) with data_in_last=1 -> 19 bytes of 0x78, out_last only on byte 19, byte_count returns to 0 after it.
- Same stimulus as the first scenario with out_ready pattern 1,0,0,1,0,1... -> identical byte sequence, outputs stable during stalls, no drops or duplicates.
- First item of a stream is copy 16'h0005 (len 3, off 5) -> error=1 from the next cycle, three 0x00 bytes; a later literal 0x41 outputs 0x41 and error stays 1.
- HISTORY_SIZE=256: 300 literals (i mod 251), then copy 16'h00FF (off 255) -> 3 bytes equal to literals 45,46,47 (wrap correct); copy off 256 -> error=1.
- Reset asserted for 1 cycle mid-copy (after 2 of 10 bytes) -> out_valid=0 next cycle, byte_count=0; a following literal 0x5A emits 0x5A with byte_count 1.
